// File: rtl/drive_pkg.sv
// Shared types and constants for the Bluetooth drive controller:
// FSM states, motion directions, drive codes and command byte decode.
package drive_pkg;

  localparam int unsigned SPEED_W   = 4;
  localparam int unsigned SLOT_MAX  = 8;
  localparam int unsigned LEVEL_RST = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_BRAKE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    DIR_FWD   = 2'd0,
    DIR_REV   = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  localparam logic [1:0] DRV_STOP = 2'b00;
  localparam logic [1:0] DRV_FWD  = 2'b01;
  localparam logic [1:0] DRV_REV  = 2'b10;
  localparam logic [1:0] DRV_TURN = 2'b11;

  localparam logic [7:0] CMD_F  = 8'h46;
  localparam logic [7:0] CMD_B  = 8'h42;
  localparam logic [7:0] CMD_L  = 8'h4C;
  localparam logic [7:0] CMD_R  = 8'h52;
  localparam logic [7:0] CMD_S  = 8'h53;
  localparam logic [7:0] CMD_D0 = 8'h30;
  localparam logic [7:0] CMD_D9 = 8'h39;

  typedef struct packed {
    logic               is_dir;
    dir_e               dir;
    logic               is_stop;
    logic               is_digit;
    logic [SPEED_W-1:0] level;
    logic               is_err;
  } cmd_t;

  function automatic cmd_t decode_cmd(input logic [7:0] b);
    cmd_t c;
    c     = '0;
    c.dir = DIR_FWD;
    case (b)
      CMD_F: begin c.is_dir = 1'b1; c.dir = DIR_FWD;   end
      CMD_B: begin c.is_dir = 1'b1; c.dir = DIR_REV;   end
      CMD_L: begin c.is_dir = 1'b1; c.dir = DIR_LEFT;  end
      CMD_R: begin c.is_dir = 1'b1; c.dir = DIR_RIGHT; end
      CMD_S: c.is_stop = 1'b1;
      default: begin
        if (b >= CMD_D0 && b <= CMD_D9) begin
          c.is_digit = 1'b1;
          c.level    = b[SPEED_W-1:0];
        end else begin
          c.is_err = 1'b1;
        end
      end
    endcase
    return c;
  endfunction

  function automatic logic [1:0] drive_code(input dir_e d);
    case (d)
      DIR_FWD: return DRV_FWD;
      DIR_REV: return DRV_REV;
      default: return DRV_TURN;
    endcase
  endfunction

  // {dir_l, dir_r}; 1 = wheel turns forward
  function automatic logic [1:0] dir_bits(input dir_e d);
    case (d)
      DIR_FWD:  return 2'b11;
      DIR_REV:  return 2'b00;
      DIR_LEFT: return 2'b01;
      default:  return 2'b10;
    endcase
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running divider: tick_c is high for one cycle out of every DIV cycles.
module tick_gen #(
  parameter int unsigned DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic tick_c
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  assign tick_c = (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (tick_c) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/drive_ctrl.sv
// Two-motor drive controller: decodes UART command bytes into a run/brake
// FSM with speed ramping, a receive watchdog and slot-based PWM.
module drive_ctrl
  import drive_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 50_000_000,
  parameter int unsigned RAMP_DIV    = 1_000_000,
  parameter int unsigned PWM_DIV     = 1_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic [1:0] drive,
  output logic       dir_l,
  output logic       dir_r,
  output logic       pwm_l,
  output logic       pwm_r,
  output logic       cmd_err
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0]    WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [SPEED_W-1:0] SLOT_TOP = SPEED_W'(SLOT_MAX);
  localparam logic [SPEED_W-1:0] LVL_RST  = SPEED_W'(LEVEL_RST);

  state_e             state_q, state_d;
  dir_e               dir_q, dir_d;
  dir_e               pend_dir_q, pend_dir_d;
  logic               pend_vld_q, pend_vld_d;
  logic [SPEED_W-1:0] level_q, level_d;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic [SPEED_W-1:0] slot_q, slot_d;
  logic [SPEED_W-1:0] target_c;
  logic [WD_W-1:0]    wdog_q, wdog_d;

  logic [1:0] drive_d;
  logic [1:0] dir_lr_d;
  logic       pwm_d;
  logic       err_d;

  logic ramp_tick_c;
  logic pwm_tick_c;
  cmd_t cmd_c;
  logic dir_cmd_c;
  logic stop_cmd_c;

  tick_gen #(.DIV(RAMP_DIV)) u_ramp_tick (
    .clk    (clk),
    .rst    (rst),
    .tick_c (ramp_tick_c)
  );

  tick_gen #(.DIV(PWM_DIV)) u_pwm_tick (
    .clk    (clk),
    .rst    (rst),
    .tick_c (pwm_tick_c)
  );

  assign cmd_c      = decode_cmd(rx_data);
  assign dir_cmd_c  = rx_valid & cmd_c.is_dir;
  assign stop_cmd_c = rx_valid & cmd_c.is_stop;

  // FSM state register plus the datapath registers that follow it
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      dir_q      <= DIR_FWD;
      pend_dir_q <= DIR_FWD;
      pend_vld_q <= 1'b0;
      level_q    <= LVL_RST;
      speed_q    <= '0;
      slot_q     <= '0;
      wdog_q     <= '0;
      drive      <= DRV_STOP;
      dir_l      <= 1'b1;
      dir_r      <= 1'b1;
      pwm_l      <= 1'b0;
      pwm_r      <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      pend_dir_q <= pend_dir_d;
      pend_vld_q <= pend_vld_d;
      level_q    <= level_d;
      speed_q    <= speed_d;
      slot_q     <= slot_d;
      wdog_q     <= wdog_d;
      drive      <= drive_d;
      dir_l      <= dir_lr_d[1];
      dir_r      <= dir_lr_d[0];
      pwm_l      <= pwm_d;
      pwm_r      <= pwm_d;
      cmd_err    <= err_d;
    end
  end

  // Next state, pending direction and watchdog
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    pend_dir_d = pend_dir_q;
    pend_vld_d = pend_vld_q;
    level_d    = level_q;
    wdog_d     = '0;
    err_d      = 1'b0;

    if (rx_valid) begin
      err_d = cmd_c.is_err;
      if (cmd_c.is_digit) begin
        level_d = cmd_c.level;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (dir_cmd_c) begin
          state_d = ST_RUN;
          dir_d   = cmd_c.dir;
        end
      end
      ST_RUN: begin
        // any received byte reloads the watchdog, even in its expiry cycle
        if (dir_cmd_c && (cmd_c.dir != dir_q)) begin
          state_d    = ST_BRAKE;
          pend_vld_d = 1'b1;
          pend_dir_d = cmd_c.dir;
        end else if (stop_cmd_c) begin
          state_d    = ST_BRAKE;
          pend_vld_d = 1'b0;
        end else if (!rx_valid && (wdog_q == WD_LAST)) begin
          state_d    = ST_BRAKE;
          pend_vld_d = 1'b0;
        end else if (!rx_valid) begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      ST_BRAKE: begin
        if (dir_cmd_c) begin
          pend_vld_d = 1'b1;
          pend_dir_d = cmd_c.dir;
        end else if (stop_cmd_c) begin
          pend_vld_d = 1'b0;
        end
        // a byte arriving in the exit cycle still steers where we go
        if (speed_q == '0) begin
          if (pend_vld_d) begin
            state_d = ST_RUN;
            dir_d   = pend_dir_d;
          end else begin
            state_d = ST_IDLE;
          end
          pend_vld_d = 1'b0;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        pend_vld_d = 1'b0;
      end
    endcase
  end

  // Speed ramp, PWM slot and registered output values
  always_comb begin
    target_c = (state_q == ST_RUN) ? level_q : '0;
    speed_d  = speed_q;
    slot_d   = slot_q;

    if (ramp_tick_c) begin
      if (speed_q < target_c) begin
        speed_d = speed_q + SPEED_W'(1);
      end else if (speed_q > target_c) begin
        speed_d = speed_q - SPEED_W'(1);
      end
    end

    if (pwm_tick_c) begin
      slot_d = (slot_q == SLOT_TOP) ? '0 : slot_q + SPEED_W'(1);
    end

    drive_d  = (state_d == ST_IDLE) ? DRV_STOP : drive_code(dir_d);
    dir_lr_d = dir_bits(dir_d);
    pwm_d    = (slot_d < speed_d);
  end

endmodule

// File: tb/tb_drive_ctrl.sv
// Scoreboard bench for drive_ctrl: a rule-level model predicts every output
// cycle, a monitor on the falling edge compares against the DUT.
module tb_drive_ctrl;

  localparam int unsigned T_CYC = 100;
  localparam int unsigned R_DIV = 4;
  localparam int unsigned P_DIV = 1;

  localparam logic [7:0] K_F = 8'h46;
  localparam logic [7:0] K_B = 8'h42;
  localparam logic [7:0] K_L = 8'h4C;
  localparam logic [7:0] K_R = 8'h52;
  localparam logic [7:0] K_S = 8'h53;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_BRAKE = 2;

  typedef struct packed {
    logic [1:0] drive;
    logic       dl;
    logic       dr;
    logic       pl;
    logic       pr;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [1:0] drive;
  logic       dir_l, dir_r, pwm_l, pwm_r, cmd_err;

  int checks = 0;
  int errors = 0;

  exp_t exp_q[$];

  // reference model state
  int         mode = M_IDLE;
  logic [7:0] cur = K_F;
  logic [7:0] pend = 8'h00;
  int         level = 5;
  int         speed = 0;
  int         quiet = 0;
  int         k = 0;
  bit         m_err = 1'b0;
  bit         seen_rst = 1'b0;

  drive_ctrl #(
    .TIMEOUT_CYC (T_CYC),
    .RAMP_DIV    (R_DIV),
    .PWM_DIV     (P_DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .drive    (drive),
    .dir_l    (dir_l),
    .dir_r    (dir_r),
    .pwm_l    (pwm_l),
    .pwm_r    (pwm_r),
    .cmd_err  (cmd_err)
  );

  always #5 clk = ~clk;

  function automatic bit is_dir_byte(input logic [7:0] b);
    return (b == K_F) || (b == K_B) || (b == K_L) || (b == K_R);
  endfunction

  function automatic bit is_digit_byte(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

  // One rising edge of the specified behaviour, from the rules in plain terms
  task automatic model_edge(input logic r, input logic v, input logic [7:0] b);
    int  old_mode, old_speed, old_level, tgt;
    bit  dcmd, scmd;
    if (r) begin
      mode = M_IDLE; cur = K_F; pend = 8'h00; level = 5; speed = 0;
      quiet = 0; k = 0; m_err = 1'b0; seen_rst = 1'b1;
    end else begin
      old_mode  = mode;
      old_speed = speed;
      old_level = level;
      k = k + 1;
      dcmd  = v && is_dir_byte(b);
      scmd  = v && (b == K_S);
      m_err = v && !(is_dir_byte(b) || b == K_S || is_digit_byte(b));
      if (v && is_digit_byte(b)) level = int'(b) - 48;
      if (k % R_DIV == 0) begin
        tgt = (old_mode == M_RUN) ? old_level : 0;
        if (speed < tgt) speed = speed + 1;
        else if (speed > tgt) speed = speed - 1;
      end
      case (old_mode)
        M_IDLE: begin
          if (dcmd) begin mode = M_RUN; cur = b; quiet = 0; end
        end
        M_RUN: begin
          if (v) begin
            quiet = 0;
            if (dcmd && b != cur) begin mode = M_BRAKE; pend = b; end
            else if (scmd) begin mode = M_BRAKE; pend = 8'h00; end
          end else begin
            quiet = quiet + 1;
            if (quiet >= T_CYC) begin mode = M_BRAKE; pend = 8'h00; quiet = 0; end
          end
        end
        default: begin
          if (dcmd) pend = b;
          else if (scmd) pend = 8'h00;
          if (old_speed == 0) begin
            if (pend != 8'h00) begin mode = M_RUN; cur = pend; end
            else mode = M_IDLE;
            pend = 8'h00;
            quiet = 0;
          end
        end
      endcase
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    int   slot;
    slot = (k / P_DIV) % 9;
    if (mode == M_IDLE) e.drive = 2'b00;
    else if (cur == K_F) e.drive = 2'b01;
    else if (cur == K_B) e.drive = 2'b10;
    else e.drive = 2'b11;
    e.dl  = (cur == K_F) || (cur == K_R);
    e.dr  = (cur == K_F) || (cur == K_L);
    e.pl  = slot < speed;
    e.pr  = slot < speed;
    e.err = m_err;
    return e;
  endfunction

  // stimulus side: predict the response of every edge
  always @(posedge clk) begin
    model_edge(rst, rx_valid, rx_data);
    if (seen_rst) exp_q.push_back(model_out());
  end

  // checking side: compare whatever the DUT presents against the prediction
  always @(negedge clk) begin
    exp_t e;
    exp_t got;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = {drive, dir_l, dir_r, pwm_l, pwm_r, cmd_err};
      checks = checks + 1;
      if (got !== e) begin
        errors = errors + 1;
        $display("FAIL outputs t=%0t got drive=%b dir=%b%b pwm=%b%b err=%b want drive=%b dir=%b%b pwm=%b%b err=%b",
                 $time, got.drive, got.dl, got.dr, got.pl, got.pr, got.err,
                 e.drive, e.dl, e.dr, e.pl, e.pr, e.err);
      end
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'h00;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    rx_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [7:0] pick_byte();
    int unsigned r;
    r = $urandom_range(0, 15);
    case (r)
      0, 1:    return K_F;
      2, 3:    return K_B;
      4:       return K_L;
      5:       return K_R;
      6, 7:    return K_S;
      8, 9, 10, 11: return 8'(8'h30 + $urandom_range(0, 9));
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    repeat (3) @(negedge clk);

    // reset state held while rst is asserted
    checks = checks + 1;
    if ({drive, dir_l, dir_r, pwm_l, pwm_r, cmd_err} !== 7'b00_11_00_0) begin
      errors = errors + 1;
      $display("FAIL reset state t=%0t drive=%b dir=%b%b pwm=%b%b err=%b",
               $time, drive, dir_l, dir_r, pwm_l, pwm_r, cmd_err);
    end
    rst = 1'b0;

    // forward from idle, ramp to the default level
    send(K_F);
    idle(40);

    // full speed forward, then reverse through a brake
    send(8'h39);
    idle(50);
    send(K_B);
    idle(60);

    // watchdog expiry on a right turn
    do_reset();
    send(K_R);
    idle(140);
    checks = checks + 1;
    if ({drive, pwm_l, pwm_r} !== 4'b00_00) begin
      errors = errors + 1;
      $display("FAIL expired wait t=%0t drive=%b pwm=%b%b (want idle, pwm off)",
               $time, drive, pwm_l, pwm_r);
    end

    // unknown byte in idle and in run
    send(8'h41);
    idle(3);
    send(K_F);
    idle(6);
    send(8'h41);
    idle(8);

    // stop arriving on the exact expiry cycle
    do_reset();
    send(K_L);
    idle(99);
    send(K_S);
    idle(40);

    // reset in the middle of a brake with a pending direction
    do_reset();
    send(K_B);
    idle(30);
    send(K_F);
    idle(3);
    do_reset();
    idle(20);

    // randomized traffic with occasional long silences and resets
    for (int i = 0; i < 160; i++) begin
      if ($urandom_range(0, 39) == 0) do_reset();
      send(pick_byte());
      if ($urandom_range(0, 7) == 0) idle(int'($urandom_range(90, 140)));
      else idle(int'($urandom_range(0, 30)));
    end

    idle(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
